pixel_stream_tx: RTL and testbench
==================================

Name: pixel_stream_tx

Overview:
- Raster transmitter: drains pixels from an upstream valid/ready source and emits the en/hsync/vsync/data pixel stream consumed by the edge-detection pipeline.
- Generates active-video, horizontal-blank and vertical-blank timing for frames of WIDTH x HEIGHT pixels.
- Sits between the frame source (memory reader or test pattern generator) and the 3x3 window/Sobel datapath. It is the producing end of that stream interface.

Parameters:
- WIDTH, 640: active pixels per line.
- HEIGHT, 480: active lines per frame.
- H_BLANK, 16: blank cycles after each line's active pixels. Must be >= HSYNC_LEN.
- HSYNC_LEN, 4: hsync pulse length in cycles. Must be >= 1.
- V_BLANK, 2: blank lines after the last active line. Must be >= VSYNC_LEN.
- VSYNC_LEN, 1: vsync pulse length in lines. Must be >= 1.
- FILL_PIXEL, 24'h000000: pixel driven on underrun (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a frame; sampled only in IDLE or on the last cycle of a frame.
- s_valid  in  1  upstream pixel valid.
- s_data  in  `PIXEL_SIZE  upstream pixel, {B,G,R} byte order.
- s_ready  out  1  pixel accepted this cycle when s_valid && s_ready.
- en  out  1  output pixel valid (active video).
- hsync  out  1  horizontal sync, active-high.
- vsync  out  1  vertical sync, active-high.
- data  out  `PIXEL_SIZE  output pixel. Zero whenever en=0.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse on the final cycle of a frame.
- underrun_cnt  out  16  saturating count of cycles in which active video wanted a pixel and s_valid=0.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, col=0, row=0. Outputs reset values: en, hsync, vsync, data, busy, frame_done all 0; underrun_cnt=0; s_ready=0.
- Counters: col counts 0..WIDTH+H_BLANK-1; row counts 0..HEIGHT+V_BLANK-1. Widths are $clog2 of those totals. Both wrap to 0.
- States:
  - IDLE: start=1 -> ACTIVE with col=row=0.
  - ACTIVE (row<HEIGHT, col<WIDTH): on transfer, advance col; at col=WIDTH-1 -> HBLANK.
  - HBLANK: advance col each cycle. At the last blank cycle col->0 and row++. Next state is ACTIVE if row+1<HEIGHT, otherwise VBLANK.
  - VBLANK: col/row free-run through V_BLANK full lines. At the final cycle, frame_done=1; next state is ACTIVE (row=0) if start=1, else IDLE.
- s_ready: combinational; 1 iff state==ACTIVE.
- Stall: in ACTIVE with s_valid=0, col holds, en=0, and underrun_cnt increments (saturating at 16'hFFFF). Line timing stretches accordingly.
- Latency: en/data/hsync/vsync are registered. A pixel accepted in cycle N appears on data with en=1 in cycle N+1.
- hsync=1 for the first HSYNC_LEN cycles of HBLANK, on every line including VBLANK lines (registered alignment as above).
- vsync=1 for all cycles of the first VSYNC_LEN VBLANK lines.
- busy=1 in every state except IDLE.
- start is ignored while mid-frame. A frame cannot be aborted except by reset.
- Reset mid-frame: immediate return to IDLE. The partial frame is discarded and no frame_done is generated.
- With WIDTH=1 the transfer cycle goes directly to HBLANK. H_BLANK=0 or V_BLANK=0 is illegal; flag it with an elaboration-time $error.

Optional Feature:
- Macro: PIXEL_TX_UNDERRUN_FILL_EN.
- Defined: in ACTIVE with s_valid=0, drive en=1, data=FILL_PIXEL and advance col as if a transfer occurred, so line timing is fixed. s_ready stays 1 and underrun_cnt still increments.
- Undefined: stall behaviour as described above.

Decomposition:
- global.vh (shared): `PIXEL_SIZE; state encodings PTX_IDLE=2'd0, PTX_ACTIVE=2'd1, PTX_HBLANK=2'd2, PTX_VBLANK=2'd3; underrun counter width constant.
- Sub-module raster_counter: col/row counters with advance enable, wrap, and last_col/last_row/in_hblank/in_vblank decodes.
- The top of this block holds the FSM, handshake and output registers.

Test Plan (WIDTH=4, HEIGHT=2, H_BLANK=3, HSYNC_LEN=1, V_BLANK=1, VSYNC_LEN=1; line = 7 cycles, frame = 21 cycles):
- Reset then start pulse with s_valid=1 and s_data=1,2,3,...
  -> en pattern 1111000 per active line; data 1..8 in order.
  -> hsync high 1 cycle after each line's 4th pixel.
  -> vsync high for the 7 VBLANK cycles; frame_done pulses at cycle 21; busy then falls.
- Same, but drop s_valid for 2 cycles mid-line 0
  -> en gap of 2 cycles; pixels still 1..8 with none lost; frame = 23 cycles; underrun_cnt=2.
- start held high continuously
  -> back-to-back frames; no IDLE cycle; row restarts at 0 immediately after frame_done.
- reset asserted during line 1 col 2
  -> all outputs 0 asynchronously (before the next clk edge); a later start restarts the frame at pixel 0.
- With PIXEL_TX_UNDERRUN_FILL_EN, FILL_PIXEL=24'hFF00FF, s_valid=0 for the whole frame
  -> 8 en cycles all with data=24'hFF00FF; frame = 21 cycles; underrun_cnt=8.
- Hold s_valid=0 in ACTIVE for 70000 cycles -> underrun_cnt saturates at 16'hFFFF without wrapping.

Source files
------------

// File: rtl/pixel_stream_tx_pkg.sv
// Shared types and constants for the pixel stream transmitter.
package pixel_stream_tx_pkg;

   localparam int unsigned PIXEL_SIZE = 24;
   localparam int unsigned UNDERRUN_W = 16;

   typedef enum logic [1:0] {
      PTX_IDLE   = 2'd0,
      PTX_ACTIVE = 2'd1,
      PTX_HBLANK = 2'd2,
      PTX_VBLANK = 2'd3
   } ptx_state_e;

   // Pixel payload, {B,G,R} byte order.
   typedef struct packed {
      logic [7:0] b;
      logic [7:0] g;
      logic [7:0] r;
   } pixel_t;

   function automatic logic [UNDERRUN_W-1:0] sat_inc(input logic [UNDERRUN_W-1:0] v);
      return (&v) ? v : v + UNDERRUN_W'(1);
   endfunction

endpackage

// File: rtl/pixel_stream_tx_raster_counter.sv
// Column/row raster counters with wrap and the position decodes used by the transmitter FSM.
module pixel_stream_tx_raster_counter #(
   parameter int unsigned WIDTH     = 640,
   parameter int unsigned HEIGHT    = 480,
   parameter int unsigned H_BLANK   = 16,
   parameter int unsigned HSYNC_LEN = 4,
   parameter int unsigned V_BLANK   = 2,
   parameter int unsigned VSYNC_LEN = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic adv,
   output logic last_col,
   output logic last_row,
   output logic last_act_col,
   output logic last_act_row,
   output logic hsync_win,
   output logic vsync_win
);

   localparam int unsigned H_TOTAL = WIDTH + H_BLANK;
   localparam int unsigned V_TOTAL = HEIGHT + V_BLANK;
   localparam int unsigned COL_W   = $clog2(H_TOTAL);
   localparam int unsigned ROW_W   = $clog2(V_TOTAL);

   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             in_hblank;
   logic             in_vblank;

   always_comb begin
      last_col     = (col_q == COL_W'(H_TOTAL - 1));
      last_row     = (row_q == ROW_W'(V_TOTAL - 1));
      last_act_col = (col_q == COL_W'(WIDTH - 1));
      last_act_row = (row_q == ROW_W'(HEIGHT - 1));
      in_hblank    = (32'(col_q) >= WIDTH);
      in_vblank    = (32'(row_q) >= HEIGHT);
      hsync_win    = in_hblank && (32'(col_q) < WIDTH + HSYNC_LEN);
      vsync_win    = in_vblank && (32'(row_q) < HEIGHT + VSYNC_LEN);
   end

   // Column wraps into the next row; the row wraps at the end of the frame.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clear) begin
         col_d = '0;
         row_d = '0;
      end else if (adv) begin
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + ROW_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

endmodule

// File: rtl/pixel_stream_tx.sv
// Raster pixel transmitter: valid/ready sink to en/hsync/vsync/data stream.
// Build option PIXEL_TX_UNDERRUN_FILL_EN replaces stalls with FILL_PIXEL so line timing stays fixed.
module pixel_stream_tx
   import pixel_stream_tx_pkg::*;
#(
   parameter int unsigned           WIDTH      = 640,
   parameter int unsigned           HEIGHT     = 480,
   parameter int unsigned           H_BLANK    = 16,
   parameter int unsigned           HSYNC_LEN  = 4,
   parameter int unsigned           V_BLANK    = 2,
   parameter int unsigned           VSYNC_LEN  = 1,
   parameter logic [PIXEL_SIZE-1:0] FILL_PIXEL = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  s_valid,
   input  logic [PIXEL_SIZE-1:0] s_data,
   output logic                  s_ready,
   output logic                  en,
   output logic                  hsync,
   output logic                  vsync,
   output logic [PIXEL_SIZE-1:0] data,
   output logic                  busy,
   output logic                  frame_done,
   output logic [UNDERRUN_W-1:0] underrun_cnt
);

   if (H_BLANK == 0 || V_BLANK == 0) begin : g_blank_chk
      $error("pixel_stream_tx: H_BLANK and V_BLANK must be non-zero");
   end
   if (HSYNC_LEN < 1 || HSYNC_LEN > H_BLANK) begin : g_hsync_chk
      $error("pixel_stream_tx: HSYNC_LEN must be in 1..H_BLANK");
   end
   if (VSYNC_LEN < 1 || VSYNC_LEN > V_BLANK) begin : g_vsync_chk
      $error("pixel_stream_tx: VSYNC_LEN must be in 1..V_BLANK");
   end

   ptx_state_e            state_q, state_d;
   logic                  en_q, en_d;
   logic                  hsync_q, hsync_d;
   logic                  vsync_q, vsync_d;
   pixel_t                data_q, data_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [UNDERRUN_W-1:0] under_q, under_d;

   logic adv, clr;
   logic last_col, last_row, last_act_col, last_act_row;
   logic hsync_win, vsync_win;
   pixel_t px_in;

   pixel_stream_tx_raster_counter #(
      .WIDTH     (WIDTH),
      .HEIGHT    (HEIGHT),
      .H_BLANK   (H_BLANK),
      .HSYNC_LEN (HSYNC_LEN),
      .V_BLANK   (V_BLANK),
      .VSYNC_LEN (VSYNC_LEN)
   ) u_raster (
      .clk          (clk),
      .reset        (reset),
      .clear        (clr),
      .adv          (adv),
      .last_col     (last_col),
      .last_row     (last_row),
      .last_act_col (last_act_col),
      .last_act_row (last_act_row),
      .hsync_win    (hsync_win),
      .vsync_win    (vsync_win)
   );

   assign s_ready = (state_q == PTX_ACTIVE);

   // Next state, counter control and next values of every registered output.
   always_comb begin
      state_d = state_q;
      adv     = 1'b0;
      clr     = 1'b0;
      en_d    = 1'b0;
      done_d  = 1'b0;
      under_d = under_q;
      px_in   = s_valid ? pixel_t'(s_data) : pixel_t'(FILL_PIXEL);
      hsync_d = (state_q != PTX_IDLE) && hsync_win;
      vsync_d = vsync_win;

      unique case (state_q)
         PTX_IDLE: begin
            if (start) begin
               state_d = PTX_ACTIVE;
               clr     = 1'b1;
            end
         end
         PTX_ACTIVE: begin
            if (!s_valid) under_d = sat_inc(under_q);
`ifdef PIXEL_TX_UNDERRUN_FILL_EN
            adv  = 1'b1;
            en_d = 1'b1;
`else
            adv  = s_valid;
            en_d = s_valid;
`endif
            if (adv && last_act_col) state_d = PTX_HBLANK;
         end
         PTX_HBLANK: begin
            adv = 1'b1;
            if (last_col) state_d = last_act_row ? PTX_VBLANK : PTX_ACTIVE;
         end
         PTX_VBLANK: begin
            adv = 1'b1;
            if (last_col && last_row) begin
               done_d  = 1'b1;
               state_d = start ? PTX_ACTIVE : PTX_IDLE;
            end
         end
         default: state_d = PTX_IDLE;
      endcase

      data_d = en_d ? px_in : '0;
      busy_d = (state_d != PTX_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= PTX_IDLE;
         en_q    <= 1'b0;
         hsync_q <= 1'b0;
         vsync_q <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         under_q <= '0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         under_q <= under_d;
      end
   end

   assign en           = en_q;
   assign hsync        = hsync_q;
   assign vsync        = vsync_q;
   assign data         = data_q;
   assign busy         = busy_q;
   assign frame_done   = done_q;
   assign underrun_cnt = under_q;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Bench for pixel_stream_tx: directed table, corner sequences and random frames against a stream-level model.
module tb_pixel_stream_tx;
   import pixel_stream_tx_pkg::*;

   localparam int unsigned W  = 4;
   localparam int unsigned H  = 2;
   localparam int unsigned HB = 3;
   localparam int unsigned HS = 1;
   localparam int unsigned VB = 1;
   localparam int unsigned VS = 1;
   localparam int unsigned HT = W + HB;
   localparam logic [23:0] FILLPX = 24'hFF00FF;

   logic        clk, reset, start, s_valid, s_ready;
   logic [23:0] s_data, data;
   logic        en, hsync, vsync, busy, frame_done;
   logic [15:0] underrun_cnt;

   pixel_stream_tx #(
      .WIDTH(W), .HEIGHT(H), .H_BLANK(HB), .HSYNC_LEN(HS),
      .V_BLANK(VB), .VSYNC_LEN(VS), .FILL_PIXEL(FILLPX)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .en(en), .hsync(hsync), .vsync(vsync), .data(data),
      .busy(busy), .frame_done(frame_done), .underrun_cnt(underrun_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        en;
      logic        hs;
      logic        vs;
      logic        fd;
      logic [23:0] data;
   } out_t;

   typedef struct {
      int          gap;
      logic [23:0] pix;
   } ent_t;

   typedef struct {
      logic [31:0] gaps;
      int          exp_len;
      int          exp_under;
   } vec_t;

   ent_t        ent_q[$];
   out_t        exp_q[$];
   int          exp_under;
   int          pend_gap;
   logic [23:0] next_pix;
   int          n_cmp, n_bad;
   vec_t        tbl[4];

   task automatic check_out(input string name, input out_t exp);
      out_t got;
      got = {en, hsync, vsync, frame_done, data};
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got en=%0b hs=%0b vs=%0b fd=%0b data=%06h, expected en=%0b hs=%0b vs=%0b fd=%0b data=%06h",
                  name, got.en, got.hs, got.vs, got.fd, got.data, exp.en, exp.hs, exp.vs, exp.fd, exp.data);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic void push_exp(input bit e, input bit hs, input bit vs, input bit fd, input logic [23:0] d);
      out_t o;
      o = {e, hs, vs, fd, d};
      exp_q.push_back(o);
   endfunction

   // Expected output stream of one frame. max_gap>0 adds random stalls; in fill builds max_gap<0 starves every slot.
   function automatic void add_frame(input int max_gap);
      ent_t e;
      bit   v;
      if (exp_q.size() == 0) pend_gap = 0;
      for (int r = 0; r < int'(H); r++) begin
         for (int p = 0; p < int'(W); p++) begin
`ifdef PIXEL_TX_UNDERRUN_FILL_EN
            v = (max_gap < 0) ? 1'b0 : ((max_gap == 0) ? 1'b1 : 1'($urandom_range(1, 0)));
            if (!v) begin
               pend_gap++;
               exp_under++;
               push_exp(1'b1, 1'b0, 1'b0, 1'b0, FILLPX);
            end else begin
               e.gap = pend_gap;
               e.pix = next_pix;
               ent_q.push_back(e);
               pend_gap = 0;
               push_exp(1'b1, 1'b0, 1'b0, 1'b0, next_pix);
               next_pix++;
            end
`else
            v = 1'b1;
            pend_gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int g = 0; g < pend_gap; g++) push_exp(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
            exp_under += pend_gap;
            e.gap = pend_gap;
            e.pix = next_pix;
            if (v) ent_q.push_back(e);
            push_exp(1'b1, 1'b0, 1'b0, 1'b0, next_pix);
            next_pix++;
`endif
         end
         for (int b = 0; b < int'(HB); b++) push_exp(1'b0, b < int'(HS), 1'b0, 1'b0, 24'h0);
      end
      for (int vr = 0; vr < int'(VB); vr++)
         for (int cc = 0; cc < int'(HT); cc++)
            push_exp(1'b0, (cc >= int'(W)) && (cc < int'(W + HS)), vr < int'(VS),
                     (vr == int'(VB) - 1) && (cc == int'(HT) - 1), 24'h0);
   endfunction

   // Source model: decides s_valid/s_data for the cycle that follows this falling edge.
   task automatic drive_step();
      ent_t e;
      if (ent_q.size() == 0) begin
         s_valid = 1'b0;
         s_data  = 24'($urandom);
      end else if (ent_q[0].gap > 0) begin
         s_valid = 1'b0;
         s_data  = 24'($urandom);
         if (s_ready) begin
            e = ent_q[0];
            e.gap--;
            ent_q[0] = e;
         end
      end else begin
         s_valid = 1'b1;
         s_data  = ent_q[0].pix;
         if (s_ready) void'(ent_q.pop_front());
      end
   endtask

   task automatic do_reset();
      reset   = 1'b0;
      start   = 1'b0;
      s_valid = 1'b0;
      s_data  = 24'h0;
      ent_q.delete();
      exp_q.delete();
      exp_under = 0;
      pend_gap  = 0;
      next_pix  = 24'd1;
      repeat (2) @(negedge clk);
      check_out("rst_out", '0);
      check_val("rst_misc", 32'({busy, s_ready, underrun_cnt}), 32'h0);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Start from IDLE and compare the output stream against exp_q (max_n<0: whole queue).
   task automatic run_check(input bit hold, input int max_n);
      int   k;
      out_t e;
      k = 0;
      start = 1'b1;
      drive_step();
      @(negedge clk);
      check_out("idle_cycle", '0);
      check_val("busy_rise", 32'(busy), 32'h1);
      if (!hold) start = 1'b0;
      drive_step();
      while (exp_q.size() > 0 && (max_n < 0 || k < max_n)) begin
         @(negedge clk);
         e = exp_q.pop_front();
         check_out($sformatf("cyc%0d", k), e);
         k++;
         if (exp_q.size() == 0) check_val("busy_end", 32'(busy), 32'(hold));
         drive_step();
      end
   endtask

   initial begin
      int  len;
      bit  found;
      ent_t e;
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b0;
      start = 1'b0;
      s_valid = 1'b0;
      s_data = 24'h0;

`ifdef PIXEL_TX_UNDERRUN_FILL_EN
      tbl[0] = '{32'h0000_0000, 21, 0};
      tbl[1] = '{32'h0000_0200, 21, 2};
      tbl[2] = '{32'h3000_0001, 21, 1};
      tbl[3] = '{32'h0011_0000, 21, 2};
`else
      tbl[0] = '{32'h0000_0000, 21, 0};
      tbl[1] = '{32'h0000_0200, 23, 2};
      tbl[2] = '{32'h3000_0001, 25, 4};
      tbl[3] = '{32'h0011_0000, 23, 2};
`endif

      do_reset();

      // Per-pixel stall table: frame length and underrun count.
      for (int i = 0; i < 4; i++) begin
         do_reset();
         for (int p = 0; p < 8; p++) begin
            e.gap = int'(tbl[i].gaps[4*p +: 4]);
            e.pix = 24'(p + 1);
            ent_q.push_back(e);
         end
         start = 1'b1;
         drive_step();
         found = 1'b0;
         len = -1;
         for (int cyc = 1; cyc <= 200 && !found; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (frame_done) begin
               found = 1'b1;
               len = cyc - 1;
            end
            drive_step();
         end
         check_val($sformatf("tbl%0d_len", i), 32'(len), 32'(tbl[i].exp_len));
         check_val($sformatf("tbl%0d_under", i), 32'(underrun_cnt), 32'(tbl[i].exp_under));
      end

      // Plain frame, pixels 1..8.
      do_reset();
      add_frame(0);
      run_check(1'b0, -1);
      check_val("plain_under", 32'(underrun_cnt), 32'(exp_under));

      // Back-to-back frames with start held.
      do_reset();
      repeat (3) add_frame(2);
      run_check(1'b1, -1);
      check_val("b2b_under", 32'(underrun_cnt), 32'(exp_under));
      start = 1'b0;

      // Reset during line 1 col 2 clears outputs before the next edge; restart begins at pixel 1.
      do_reset();
      add_frame(0);
      run_check(1'b0, 9);
      check_val("pre_rst_en", 32'(en), 32'h1);
      #2 reset = 1'b0;
      #1;
      check_out("async_rst", '0);
      check_val("async_misc", 32'({busy, s_ready, underrun_cnt}), 32'h0);
      do_reset();
      add_frame(0);
      run_check(1'b0, -1);

`ifdef PIXEL_TX_UNDERRUN_FILL_EN
      // Source starved for the whole frame.
      do_reset();
      add_frame(-1);
      run_check(1'b0, -1);
      check_val("fill_under", 32'(underrun_cnt), 32'd8);
`endif

      // Random frames.
      do_reset();
      for (int it = 0; it < 8; it++) begin
         add_frame(3);
         run_check(1'b0, -1);
         check_val($sformatf("rnd%0d_under", it), 32'(underrun_cnt), 32'(exp_under));
         repeat ($urandom_range(3, 0)) begin
            @(negedge clk);
            drive_step();
         end
      end

`ifndef PIXEL_TX_UNDERRUN_FILL_EN
      // Endless stall in ACTIVE: counter saturates.
      do_reset();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (65534) @(negedge clk);
      check_val("sat_pre", 32'(underrun_cnt), 32'hFFFE);
      @(negedge clk);
      check_val("sat_reach", 32'(underrun_cnt), 32'hFFFF);
      repeat (4000) @(negedge clk);
      check_val("sat_hold", 32'(underrun_cnt), 32'hFFFF);
      check_val("sat_en", 32'({en, busy}), 32'h1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
